// File: rtl/rom_tx_ctrl.sv
// Baud-paced sequencer that frames each ROM word as start, 4 data bits LSB-first, stop.
// Drives the ROM address and bit index for the existing ROM and display logic.
module rom_tx_ctrl #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [3:0]  LAST_ADDR = 4'd15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] rom_data,
  output logic [3:0] nom,
  output logic [1:0] bit_idx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       bit_tick
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] nom_q, nom_d;
  logic [1:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick;
  logic [1:0] nxt_bit;

  assign tick    = (state_q != IDLE) && (div_q == DIV_MAX);
  assign nxt_bit = bit_q + 2'd1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    nom_d   = nom_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = START;
          nom_d   = 4'd0;
          bit_d   = 2'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = 8'd0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 2'd0;
          tx_d    = rom_data[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q != 2'd3) begin
            bit_d = nxt_bit;
            tx_d  = rom_data[nxt_bit];
          end else begin
            state_d = STOP;
            bit_d   = 2'd0;
            tx_d    = 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (nom_q == LAST_ADDR) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            nom_d   = 4'd0;
          end else begin
            state_d = START;
            nom_d   = nom_q + 4'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort beats every other transition, including the final stop tick.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      div_d   = 8'd0;
      nom_d   = 4'd0;
      bit_d   = 2'd0;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      nom_q   <= 4'd0;
      bit_q   <= 2'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      nom_q   <= nom_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign nom      = nom_q;
  assign bit_idx  = bit_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bit_tick = tick;

endmodule

// File: tb/tb_rom_tx_ctrl.sv
// Directed bench for rom_tx_ctrl: framing, message length, abort,
// simultaneous events, mid-frame reset, and the CLK_DIV=1 corner.
module tb_rom_tx_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start_a = 1'b0;
  logic       abort_a = 1'b0;
  logic [3:0] rom_a;
  logic [3:0] nom_a;
  logic [1:0] bit_a;
  logic       tx_a, busy_a, done_a, tick_a;

  logic       start_b = 1'b0;
  logic       abort_b = 1'b0;
  logic [3:0] rom_b;
  logic [3:0] nom_b;
  logic [1:0] bit_b;
  logic       tx_b, busy_b, done_b, tick_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // ROM images supplied as stimulus
  assign rom_a = nom_a ^ 4'hA;
  assign rom_b = 4'b1010;

  rom_tx_ctrl #(.CLK_DIV(2), .LAST_ADDR(4'd3)) u_a (
    .clk(clk), .clr(clr),
    .start(start_a), .abort(abort_a),
    .rom_data(rom_a), .nom(nom_a),
    .bit_idx(bit_a), .tx(tx_a),
    .busy(busy_a), .done(done_a),
    .bit_tick(tick_a)
  );

  rom_tx_ctrl #(.CLK_DIV(1), .LAST_ADDR(4'd0)) u_b (
    .clk(clk), .clr(clr),
    .start(start_b), .abort(abort_b),
    .rom_data(rom_b), .nom(nom_b),
    .bit_idx(bit_b), .tx(tx_b),
    .busy(busy_b), .done(done_b),
    .bit_tick(tick_b)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".tx"}, 8'(tx_a), 8'd1);
    chk({tag, ".busy"}, 8'(busy_a), 8'd0);
    chk({tag, ".done"}, 8'(done_a), 8'd0);
    chk({tag, ".nom"}, 8'(nom_a), 8'd0);
    chk({tag, ".bit"}, 8'(bit_a), 8'd0);
    chk({tag, ".tick"}, 8'(tick_a), 8'd0);
  endtask

  function automatic logic exp_tx(input int c);
    int f, p;
    logic [3:0] w;
    f = c % 12;
    p = f / 2;
    w = 4'(c / 12) ^ 4'hA;
    if (p == 0) return 1'b0;
    if (p == 5) return 1'b1;
    return w[p-1];
  endfunction

  function automatic logic [1:0] exp_bit(input int c);
    int f;
    f = c % 12;
    if (f >= 2 && f <= 9) return 2'((f - 2) / 2);
    return 2'd0;
  endfunction

  initial begin
    // reset and idle
    step(3);
    chk_idle_a("rst");
    clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle_a("idle");
    end

    // full message, start re-pulsed mid-message
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 48; c++) begin
      chk("msg.tx", 8'(tx_a), 8'(exp_tx(c)));
      chk("msg.busy", 8'(busy_a), 8'd1);
      chk("msg.done", 8'(done_a), 8'd0);
      chk("msg.nom", 8'(nom_a), 8'(c / 12));
      chk("msg.bit", 8'(bit_a), 8'(exp_bit(c)));
      chk("msg.tick", 8'(tick_a), 8'(c % 2));
      start_a = (c == 20);
      step();
    end
    start_a = 1'b0;
    chk("end.busy", 8'(busy_a), 8'd0);
    chk("end.done", 8'(done_a), 8'd1);
    chk("end.tx", 8'(tx_a), 8'd1);
    chk("end.nom", 8'(nom_a), 8'd0);

    // start on the done cycle is accepted
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("rs.busy", 8'(busy_a), 8'd1);
    chk("rs.tx", 8'(tx_a), 8'd0);
    chk("rs.nom", 8'(nom_a), 8'd0);
    chk("rs.done", 8'(done_a), 8'd0);

    // abort in word 1, bit 2, second cycle
    step(19);
    chk("ab.pre.nom", 8'(nom_a), 8'd1);
    chk("ab.pre.bit", 8'(bit_a), 8'd2);
    chk("ab.pre.tick", 8'(tick_a), 8'd1);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk_idle_a("ab");
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle_a("ab.hold");
    end

    // start and abort together in idle
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk_idle_a("sa");
    step();
    chk_idle_a("sa2");

    // restart from word 0, abort on final stop tick
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("rst2.nom", 8'(nom_a), 8'd0);
    chk("rst2.busy", 8'(busy_a), 8'd1);
    chk("rst2.tx", 8'(tx_a), 8'd0);
    step(47);
    chk("fin.nom", 8'(nom_a), 8'd3);
    chk("fin.tick", 8'(tick_a), 8'd1);
    chk("fin.tx", 8'(tx_a), 8'd1);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk_idle_a("fin.ab");

    // reset during stop of word 2
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(34);
    chk("mr.nom", 8'(nom_a), 8'd2);
    chk("mr.busy", 8'(busy_a), 8'd1);
    chk("mr.tx", 8'(tx_a), 8'd1);
    clr = 1'b0;
    step();
    chk_idle_a("mr");
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle_a("mr.idle");
    end

    // CLK_DIV=1, single word 1010
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    begin
      logic [5:0] seq;
      seq = 6'b110100;
      for (int c = 0; c < 6; c++) begin
        chk("b.tx", 8'(tx_b), 8'(seq[c]));
        chk("b.busy", 8'(busy_b), 8'd1);
        chk("b.tick", 8'(tick_b), 8'd1);
        chk("b.done", 8'(done_b), 8'd0);
        step();
      end
    end
    chk("b.end.busy", 8'(busy_b), 8'd0);
    chk("b.end.done", 8'(done_b), 8'd1);
    chk("b.end.tick", 8'(tick_b), 8'd0);
    step();
    chk("b.post.done", 8'(done_b), 8'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_tx_ctrl.md
Name: rom_tx_ctrl

Overview:
Sequencer for the 16x4 message-ROM serialiser. On a start request it walks every ROM word, one bit at a time, and transmits each word as a framed serial character on TX: start bit, 4 data bits LSB-first, stop bit. It replaces the free-running hit-pulse counter with a clocked, baud-paced controller that has a start/busy/done handshake. It also drives the word address (NOM) and bit index (BIT) for the existing ROM and display logic.

Parameters:
CLK_DIV, 4, clock cycles per serial bit period; legal range 1..255.
LAST_ADDR, 15, address of the final ROM word sent; legal range 0..15.

Ports:
clk  input  1  system clock; all state changes on rising edge.
clr  input  1  reset, synchronous, active-low.
start  input  1  begin transmission; sampled only in IDLE.
abort  input  1  cancel transmission; sampled in every non-IDLE state.
rom_data  input  4  word read from ROM at address nom (combinational ROM, stable while nom is constant).
nom  output  4  ROM word address (registered).
bit  output  2  current data-bit index within the word (registered).
tx  output  1  serial line (registered); idle level 1.
busy  output  1  high from the first START cycle until return to IDLE.
done  output  1  one-cycle pulse on normal completion.
bit_tick  output  1  one-cycle pulse on the last cycle of each bit period; 0 in IDLE.

Behaviour:
- Reset: clk edge with clr=0 forces state=IDLE, nom=0, bit=0, tx=1, busy=0, done=0, divider=0, bit_tick=0. Reset overrides start and abort.
- States: IDLE, START, DATA, STOP. State register uses 2 bits.
- Divider counts 0..CLK_DIV-1 in non-IDLE states. bit_tick = (divider==CLK_DIV-1). Divider clears on every state change. With CLK_DIV=1, bit_tick is high every non-IDLE cycle.
- IDLE: tx=1, busy=0.
  - start=1 and abort=0 at edge N: from N+1, state=START, nom=0, bit=0, tx=0, busy=1.
- START: tx=0 for CLK_DIV cycles.
  - On bit_tick: state=DATA, bit=0, tx<=rom_data[0].
- DATA: tx holds rom_data[bit] for CLK_DIV cycles.
  - On bit_tick with bit<3: bit<=bit+1, tx<=rom_data[bit+1].
  - On bit_tick with bit==3: state=STOP, tx<=1, bit<=0.
- STOP: tx=1 for CLK_DIV cycles.
  - On bit_tick with nom!=LAST_ADDR: nom<=nom+1, state=START, tx<=0.
  - On bit_tick with nom==LAST_ADDR: state=IDLE, busy<=0, done<=1 for exactly one cycle, nom<=0.
- Frame length is 6*CLK_DIV cycles per word. Full message is (LAST_ADDR+1)*6*CLK_DIV cycles, measured from the first START cycle to the first IDLE cycle.
- No idle gap between consecutive frames: STOP goes straight to START.
- nom does not wrap past LAST_ADDR. The 4-bit increment is never taken at 15.
- start while busy is ignored; it is neither queued nor restarts the message.
- abort=1 in any non-IDLE state: next cycle state=IDLE, tx=1, busy=0, nom=0, bit=0, divider=0. done is not asserted.
- abort=1 in IDLE is ignored. start and abort both 1 in IDLE: abort wins and state stays IDLE.
- abort on the same edge as the final STOP bit_tick: abort wins and done is not asserted.
- start asserted in the cycle done pulses (state already IDLE): accepted, and a new message begins next cycle.
- clr=0 mid-frame: immediate reset values on the next edge. No partial frame is completed.
- rom_data is sampled only at bit boundaries. Changes between boundaries do not affect tx.

Test Plan:
1. Reset and idle: hold clr=0 for 3 cycles, then clr=1 with no start for 10 cycles -> tx=1, busy=0, done=0, nom=0, bit=0, bit_tick=0 throughout.
2. Single word (CLK_DIV=4, LAST_ADDR=0, ROM[0]=4'b1010), pulse start -> tx sequence 0,0,1,0,1,1 with each value held exactly 4 cycles. busy high for 24 cycles. done pulses once, on the cycle busy falls. bit steps 0..3 during DATA.
3. Full message (CLK_DIV=2, LAST_ADDR=15, ROM[i]=i) -> busy high exactly 192 cycles. nom steps 0..15 with each value held 12 cycles. Decoded characters equal 0..15. Exactly one done pulse. Re-pulsing start during busy changes nothing.
4. Abort (CLK_DIV=4, LAST_ADDR=15): abort at cycle 3 of the DATA bit=2 period of word 5 -> next cycle tx=1, busy=0, nom=0, bit=0. No done. A subsequent start restarts from word 0.
5. Simultaneous events: start and abort together in IDLE -> remains IDLE. start on the done cycle -> START entered next cycle with nom=0. CLK_DIV=1 -> bit_tick high every busy cycle and frame length is 6 cycles.
6. Reset mid-operation: clr=0 during STOP of word 7 -> next edge gives all reset values. After clr=1, the block stays idle until start.
